// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : i2c_byte_master
// Summary  : Single-transaction open-drain I2C master (START, address, one
//            data byte, STOP). Define I2C_MASTER_10BIT_EN for 10-bit writes.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_byte_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic [9:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(CLK_DIV - 1);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_START = 4'd1;
    localparam logic [3:0] ST_ADDR1 = 4'd2;
    localparam logic [3:0] ST_ACK1  = 4'd3;
    localparam logic [3:0] ST_ADDR2 = 4'd4;
    localparam logic [3:0] ST_ACK2  = 4'd5;
    localparam logic [3:0] ST_WRITE = 4'd6;
    localparam logic [3:0] ST_ACKW  = 4'd7;
    localparam logic [3:0] ST_READ  = 4'd8;
    localparam logic [3:0] ST_MACK  = 4'd9;
    localparam logic [3:0] ST_STOP  = 4'd10;
    localparam logic [3:0] ST_ERR   = 4'd11;

    logic [3:0]    r_state, w_state_nxt;
    logic [1:0]    r_q, w_q_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_sh, w_sh_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_read, w_read_nxt;
    logic [7:0]    r_wdata, w_wdata_nxt;
    logic          r_rsp_valid, w_valid_nxt;
    logic          r_rsp_nack, w_nack_nxt;
    logic [7:0]    r_rsp_rdata, w_rdata_nxt;
    logic          r_scl_oe, r_sda_oe, w_scl_oe_nxt, w_sda_oe_nxt;
    logic          w_tick, w_accept, w_ready;
    logic          w_cmd_ten, w_ten;
    logic [7:0]    w_byte1, w_addr2;

`ifdef I2C_MASTER_10BIT_EN
    logic       r_ten;
    logic [7:0] r_addr_lo;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ten     <= 1'b0;
            r_addr_lo <= 8'h00;
        end else if (w_accept) begin
            r_ten     <= w_cmd_ten;
            r_addr_lo <= cmd_addr[7:0];
        end
    end

    assign w_cmd_ten = |cmd_addr[9:7];
    assign w_byte1   = w_cmd_ten ? {5'b11110, cmd_addr[9:8], 1'b0} : {cmd_addr[6:0], cmd_read};
    assign w_ten     = r_ten;
    assign w_addr2   = r_addr_lo;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^cmd_addr[9:7];
    assign w_cmd_ten     = 1'b0;
    assign w_byte1       = {cmd_addr[6:0], cmd_read};
    assign w_ten         = 1'b0;
    assign w_addr2       = 8'h00;
`endif

    assign w_ready  = (r_state == ST_IDLE) && !r_rsp_valid;
    assign w_accept = cmd_valid && w_ready;
    assign w_tick   = (r_state != ST_IDLE) && (r_state != ST_ERR) && (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge rstn) begin : p_state
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_q         <= 2'd0;
            r_bit       <= 3'd7;
            r_sh        <= 8'h00;
            r_cnt       <= '0;
            r_read      <= 1'b0;
            r_wdata     <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_nack  <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_q         <= w_q_nxt;
            r_bit       <= w_bit_nxt;
            r_sh        <= w_sh_nxt;
            r_cnt       <= w_cnt_nxt;
            r_read      <= w_read_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_valid <= w_valid_nxt;
            r_rsp_nack  <= w_nack_nxt;
            r_rsp_rdata <= w_rdata_nxt;
            if (w_tick) begin
                r_scl_oe <= w_scl_oe_nxt;
                r_sda_oe <= w_sda_oe_nxt;
            end
        end
    end

    always_comb begin : p_next
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_bit_nxt   = r_bit;
        w_sh_nxt    = r_sh;
        w_read_nxt  = r_read;
        w_wdata_nxt = r_wdata;
        w_valid_nxt = 1'b0;
        w_nack_nxt  = r_rsp_nack;
        w_rdata_nxt = r_rsp_rdata;
        w_cnt_nxt   = (r_state == ST_IDLE || r_state == ST_ERR || w_tick) ? '0 : r_cnt + CW'(1);
        case (r_state)
            ST_IDLE: if (w_accept) begin
                w_read_nxt  = cmd_read;
                w_wdata_nxt = cmd_wdata;
                w_rdata_nxt = 8'h00;
                w_nack_nxt  = 1'b0;
                w_q_nxt     = 2'd0;
                w_bit_nxt   = 3'd7;
                w_sh_nxt    = w_byte1;
                // 10-bit reads are rejected without touching the bus
                if (w_cmd_ten && cmd_read) begin
                    w_state_nxt = ST_ERR;
                    w_nack_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: if (w_tick) begin
                if (r_q == 2'd1) begin
                    w_state_nxt = ST_ADDR1;
                    w_q_nxt     = 2'd0;
                end else begin
                    w_q_nxt = r_q + 2'd1;
                end
            end
            ST_ADDR1, ST_ADDR2, ST_WRITE: if (w_tick) begin
                if (r_q == 2'd3) begin
                    w_q_nxt = 2'd0;
                    if (r_bit == 3'd0) begin
                        w_state_nxt = (r_state == ST_ADDR1) ? ST_ACK1 :
                                      (r_state == ST_ADDR2) ? ST_ACK2 : ST_ACKW;
                    end else begin
                        w_bit_nxt = r_bit - 3'd1;
                        w_sh_nxt  = {r_sh[6:0], 1'b0};
                    end
                end else begin
                    w_q_nxt = r_q + 2'd1;
                end
            end
            ST_ACK1, ST_ACK2, ST_ACKW: if (w_tick) begin
                if (r_q == 2'd3) begin
                    w_q_nxt   = 2'd0;
                    w_bit_nxt = 3'd7;
                    if (r_rsp_nack || r_state == ST_ACKW) begin
                        w_state_nxt = ST_STOP;
                    end else if (r_state == ST_ACK1 && w_ten) begin
                        w_state_nxt = ST_ADDR2;
                        w_sh_nxt    = w_addr2;
                    end else if (r_read) begin
                        w_state_nxt = ST_READ;
                    end else begin
                        w_state_nxt = ST_WRITE;
                        w_sh_nxt    = r_wdata;
                    end
                end else begin
                    w_q_nxt = r_q + 2'd1;
                    if (r_q == 2'd2 && sda_in) w_nack_nxt = 1'b1;
                end
            end
            ST_READ: if (w_tick) begin
                if (r_q == 2'd3) begin
                    w_q_nxt = 2'd0;
                    if (r_bit == 3'd0) begin
                        w_state_nxt = ST_MACK;
                        w_rdata_nxt = r_sh;
                    end else begin
                        w_bit_nxt = r_bit - 3'd1;
                    end
                end else begin
                    w_q_nxt = r_q + 2'd1;
                    if (r_q == 2'd2) w_sh_nxt = {r_sh[6:0], sda_in};
                end
            end
            ST_MACK: if (w_tick) begin
                if (r_q == 2'd3) begin
                    w_state_nxt = ST_STOP;
                    w_q_nxt     = 2'd0;
                end else begin
                    w_q_nxt = r_q + 2'd1;
                end
            end
            ST_STOP: if (w_tick) begin
                if (r_q == 2'd2) begin
                    w_state_nxt = ST_IDLE;
                    w_q_nxt     = 2'd0;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_q_nxt = r_q + 2'd1;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pad levels are decoded from the phase being entered and latched on the tick
    always_comb begin : p_pads
        w_scl_oe_nxt = 1'b0;
        w_sda_oe_nxt = 1'b0;
        case (w_state_nxt)
            ST_START: w_sda_oe_nxt = (w_q_nxt == 2'd1);
            ST_ADDR1, ST_ADDR2, ST_WRITE: begin
                w_scl_oe_nxt = (w_q_nxt == 2'd0) || (w_q_nxt == 2'd3);
                w_sda_oe_nxt = ~w_sh_nxt[7];
            end
            ST_ACK1, ST_ACK2, ST_ACKW, ST_READ, ST_MACK:
                w_scl_oe_nxt = (w_q_nxt == 2'd0) || (w_q_nxt == 2'd3);
            ST_STOP: begin
                w_scl_oe_nxt = (w_q_nxt == 2'd0);
                w_sda_oe_nxt = (w_q_nxt != 2'd2);
            end
            default: ;
        endcase
    end

    assign cmd_ready = w_ready;
    assign busy      = (r_state != ST_IDLE) || r_rsp_valid;
    assign rsp_valid = r_rsp_valid;
    assign rsp_nack  = r_rsp_nack;
    assign rsp_rdata = r_rsp_rdata;
    assign scl_oe    = r_scl_oe;
    assign sda_oe    = r_sda_oe;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_byte_master
// Summary  : Self-checking bench for i2c_byte_master with a behavioural I2C
//            slave and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_master;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cmd_valid, cmd_ready, cmd_read;
    logic [9:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
    logic [7:0] rsp_rdata;
    logic       sda_line, scl_line;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Slave configuration and bus observations
    bit         slv_present;
    int         slv_nidx;
    logic [7:0] slv_rdata;
    logic       drive_low = 1'b0;
    logic [7:0] q_bytes[$];
    logic       q_acks[$];
    int         stops;

    // Reference model outputs
    logic [7:0] exp_bytes[$];
    logic       exp_nack;
    logic [7:0] exp_rdata;
    int         exp_lat;

    assign scl_line = ~scl_oe;
    assign sda_line = ~(sda_oe | drive_low);

    always #5 clk = ~clk;

    i2c_byte_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_line)
    );

    // Behavioural slave: samples the bus mid-cycle, detects START/STOP and
    // SCL edges, records bytes and ninth bits, drives ACK and read data.
    logic       ps = 1'b1, pc = 1'b1, in_xfer = 1'b0, rd_mode = 1'b0;
    int         bitn = 0, bytn = 0;
    logic [7:0] ssh = 8'h00;
    always @(negedge clk) begin
        logic s, c;
        s = sda_line;
        c = scl_line;
        if (pc && c && ps && !s) begin
            in_xfer = 1'b1; bitn = 0; bytn = 0; drive_low = 1'b0;
        end else if (pc && c && !ps && s) begin
            if (in_xfer) stops++;
            in_xfer = 1'b0; drive_low = 1'b0;
        end else if (in_xfer && !pc && c) begin
            if (bitn < 8) begin
                ssh = {ssh[6:0], s};
                bitn++;
                if (bitn == 8) begin
                    q_bytes.push_back(ssh);
                    if (bytn == 0) rd_mode = ssh[0];
                end
            end else begin
                q_acks.push_back(s);
                bitn = 0;
                bytn++;
            end
        end else if (in_xfer && pc && !c) begin
            if (bitn == 8)
                drive_low = slv_present && !(rd_mode && bytn == 1) && (bytn != slv_nidx);
            else if (rd_mode && bytn == 1 && slv_present && slv_nidx != 0)
                drive_low = !slv_rdata[7 - bitn];
            else
                drive_low = 1'b0;
        end
        ps = s;
        pc = c;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level expectation: bytes on the wire, response and latency
    task automatic model(input logic rd, input logic [9:0] addr, input logic [7:0] wd,
                         input bit present, input int nidx, input logic [7:0] srd);
        logic [7:0] ab[$];
        bit ten;
        int k;
        exp_bytes.delete();
        exp_nack  = 1'b0;
        exp_rdata = 8'h00;
        k = 0;
`ifdef I2C_MASTER_10BIT_EN
        ten = (addr >= 10'd128);
`else
        ten = 1'b0;
`endif
        if (ten && rd) begin
            exp_nack = 1'b1;
            exp_lat  = 2;
            return;
        end
        if (ten) begin
            ab.push_back({5'b11110, addr[9:8], 1'b0});
            ab.push_back(addr[7:0]);
        end else begin
            ab.push_back({addr[6:0], rd});
        end
        foreach (ab[i]) begin
            if (!exp_nack) begin
                exp_bytes.push_back(ab[i]);
                k++;
                if (!present || nidx == i) exp_nack = 1'b1;
            end
        end
        if (!exp_nack) begin
            k++;
            if (rd) begin
                exp_bytes.push_back(srd);
                exp_rdata = srd;
            end else begin
                exp_bytes.push_back(wd);
                if (nidx == k - 1) exp_nack = 1'b1;
            end
        end
        exp_lat = (2 + 36 * k + 3) * CLK_DIV + 1;
    endtask

    task automatic issue(input logic rd, input logic [9:0] addr, input logic [7:0] wd);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("issue.ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wd;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_read  = 1'($urandom);
        cmd_addr  = 10'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    task automatic run_cmd(input string tag, input logic rd, input logic [9:0] addr,
                           input logic [7:0] wd, input bit present, input int nidx,
                           input logic [7:0] srd);
        int n = 0;
        bit got = 0;
        bit scl_act = 0;
        model(rd, addr, wd, present, nidx, srd);
        slv_present = present; slv_nidx = nidx; slv_rdata = srd;
        q_bytes.delete(); q_acks.delete(); stops = 0;
        issue(rd, addr, wd);
        while (!got && n < 4000) begin
            @(negedge clk);
            n++;
            if (scl_oe) scl_act = 1;
            if (n == 1) begin
                check({tag, ".busy1"}, busy, 1);
                check({tag, ".ready1"}, cmd_ready, 0);
            end
            if (rsp_valid) got = 1;
        end
        check({tag, ".lat"}, got ? n : 0, exp_lat);
        check({tag, ".nack"}, rsp_nack, exp_nack);
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
        check({tag, ".busy_rsp"}, busy, 1);
        check({tag, ".scl_act"}, scl_act, (exp_lat > 2) ? 1 : 0);
        @(negedge clk);
        check({tag, ".ready2"}, cmd_ready, 1);
        check({tag, ".pulse"}, rsp_valid, 0);
        check({tag, ".hold"}, rsp_rdata, exp_rdata);
        check({tag, ".stops"}, stops, (exp_lat > 2) ? 1 : 0);
        check({tag, ".nbytes"}, q_bytes.size(), exp_bytes.size());
        foreach (exp_bytes[i])
            check($sformatf("%s.byte%0d", tag, i),
                  (i < q_bytes.size()) ? {24'h0, q_bytes[i]} : 32'hxxxxxxxx, exp_bytes[i]);
        if (rd && exp_bytes.size() == 2 && !exp_nack)
            check({tag, ".mack"}, (q_acks.size() > 1) ? {31'h0, q_acks[1]} : 32'hxxxxxxxx, 1);
    endtask

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        slv_present = 0; slv_nidx = 99; slv_rdata = 8'h00; stops = 0;
        #1;
        check("rst.scl_oe", scl_oe, 0);
        check("rst.sda_oe", sda_oe, 0);
        check("rst.ready", cmd_ready, 1);
        check("rst.busy", busy, 0);
        check("rst.valid", rsp_valid, 0);
        check("rst.nack", rsp_nack, 0);
        check("rst.rdata", rsp_rdata, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        run_cmd("wr21", 1'b0, 10'h021, 8'hA5, 1, 99, 8'h00);
        run_cmd("rd21", 1'b1, 10'h021, 8'h00, 1, 99, 8'h3C);
        run_cmd("noslv", 1'b0, 10'h055, 8'h77, 0, 99, 8'h00);
        run_cmd("dnack", 1'b0, 10'h013, 8'hC3, 1, 1, 8'h00);
        run_cmd("rdnak", 1'b1, 10'h07F, 8'h00, 1, 0, 8'hFF);

        // Reset in the first WRITE data bit while SDA is pulled low
        slv_present = 1; slv_nidx = 99;
        issue(1'b0, 10'h021, 8'h00);
        repeat (154) @(negedge clk);
        check("mid.sda_pre", sda_oe, 1);
        rstn = 1'b0;
        #1;
        check("mid.sda_oe", sda_oe, 0);
        check("mid.scl_oe", scl_oe, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("mid.ready", cmd_ready, 1);
        check("mid.busy", busy, 0);
        run_cmd("after", 1'b0, 10'h021, 8'h96, 1, 99, 8'h00);

        run_cmd("a2A5w", 1'b0, 10'h2A5, 8'h5A, 1, 99, 8'h00);
        run_cmd("a2A5r", 1'b1, 10'h2A5, 8'h00, 1, 99, 8'h81);

        for (int t = 0; t < 10; t++) begin
            logic rd;
            logic [9:0] a;
            logic [7:0] wd, srd;
            bit pres;
            int nidx;
            rd   = 1'($urandom);
            a    = 10'($urandom);
            wd   = 8'($urandom);
            srd  = 8'($urandom);
            pres = ($urandom_range(0, 3) != 0);
            nidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : 99;
            run_cmd($sformatf("rnd%0d", t), rd, a, wd, pres, nidx, srd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_byte_master.md
# i2c_byte_master

Synthesizable single-transaction I2C master that drives the open-drain `sda`/`scl` pair feeding the I2C GPIO slave on the board-level bus. It accepts one command per handshake and runs the whole bus transaction: START, address byte(s), ACK check, one data byte written or read, STOP. It then returns a single response. It sits between an on-chip command source (sequencer or APB wrapper) and the pad-level open-drain buffers.

## Interface
- `CLK_DIV`, 125: `clk` cycles per SCL quarter-period; legal range ≥ 2.
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_read`  in  1  1 = read one byte, 0 = write one byte.
- `cmd_addr`  in  10  slave address; bits [6:0] only, unless 10-bit addressing is compiled in.
- `cmd_wdata`  in  8  byte to write.
- `rsp_valid`  out  1  one-cycle pulse when the transaction ends.
- `rsp_rdata`  out  8  byte read; 0 for writes and for errors.
- `rsp_nack`  out  1  qualified by `rsp_valid`; 1 = address/data NACK or illegal command.
- `busy`  out  1  high from command accept through the `rsp_valid` cycle.
- `scl_oe`  out  1  1 = pull SCL low.
- `sda_oe`  out  1  1 = pull SDA low.
- `sda_in`  in  1  sampled SDA pad value (externally synchronized).

## Operation
- **Handshake:** a command is accepted when `cmd_valid && cmd_ready`. Fields are latched on that cycle and are don't-care afterwards.
- **Quarter tick:**
  - Counter runs 0..CLK_DIV-1 and ticks on CLK_DIV-1.
  - Counter is held at 0 in IDLE.
  - Every state/phase advance happens on a tick.
- **States:** IDLE → START → ADDR1 → ACK1 → [ADDR2 → ACK2] → WRITE → ACKW | READ → MACK → STOP → IDLE.
- **START:** 2 quarters. Q0: SCL and SDA released. Q1: SDA low with SCL high.
- **Bit cell** (4 quarters):
  - Q0: SCL low; SDA driven to the new bit value at entry.
  - Q1: SCL released.
  - Q2: SCL released; `sda_in` sampled on the last cycle of Q2.
  - Q3: SCL low.
- **Shift order:** MSB first. A bit count of 7..0 is reloaded at each byte.
- **ADDR1 (7-bit):** sends `{cmd_addr[6:0], cmd_read}`.
- **ACK1:**
  - SDA is released and sampled.
  - `sda_in` = 1 → STOP with `rsp_nack` = 1.
  - `sda_in` = 0 → WRITE or READ.
- **WRITE/ACKW:** sends `cmd_wdata`. A NACK sets `rsp_nack` but STOP still follows.
- **READ:** SDA is released and 8 bits are sampled into `rsp_rdata`.
- **MACK:** the master releases SDA (NACK), marking the last byte.
- **STOP:** 3 quarters. P0: SCL low, SDA low. P1: SCL released. P2: SDA released.
- **Response:** `rsp_valid` pulses in the cycle after the final P2 tick. The state returns to IDLE in that same cycle. `rsp_rdata` and `rsp_nack` hold their values until the next accept, which clears them.
- **Reset:** async assertion releases both pads immediately and forces IDLE. It clears `rsp_*`, `busy` and the counters; `cmd_ready` becomes 1. A bus transaction cut mid-flight is abandoned with no STOP; this is accepted behaviour.

## Timing
- **Reset values:**
  - `scl_oe` = 0, `sda_oe` = 0
  - `cmd_ready` = 1, `busy` = 0
  - `rsp_valid` = 0, `rsp_nack` = 0, `rsp_rdata` = 0
- **7-bit transaction:** 2 + 18·4 + 3 = 77 quarters. `rsp_valid` rises 77·CLK_DIV + 1 cycles after the accept cycle.
- **Address NACK:** 2 + 9·4 + 3 = 41 quarters.
- **Back-to-back commands:** the earliest next accept is the cycle after `rsp_valid`. IDLE always has at least one cycle with both pads released.
- **Pad outputs:** `scl_oe` and `sda_oe` are registered and glitch-free. They change only on tick edges.
- **No clock stretching:** SCL is never read back.

## Configuration
- **`I2C_MASTER_10BIT_EN` defined:**
  - When `cmd_addr[9:7]` ≠ 0, ADDR1 sends `{5'b11110, cmd_addr[9:8], 1'b0}`, then ACK1, then ADDR2 sends `cmd_addr[7:0]`, then ACK2.
  - A NACK at ACK2 → STOP with `rsp_nack` = 1.
  - 10-bit transactions are write-only. `cmd_read` = 1 with `cmd_addr[9:7]` ≠ 0 generates no bus activity: `rsp_valid` with `rsp_nack` = 1 occurs 2 cycles after accept.
  - A 10-bit write takes 2 + 27·4 + 3 = 113 quarters.
- **Undefined:**
  - `cmd_addr[9:7]` is ignored and ADDR2/ACK2 do not exist.
  - Every command is 7-bit.

## Test plan
- **7-bit write:** CLK_DIV=4, write addr 0x21, data 0xA5, ACKing slave model.
  - Required SDA bytes: 0x42, then 0xA5.
  - `rsp_nack` = 0.
  - `rsp_valid` 309 cycles after accept.
- **7-bit read:** read addr 0x21, slave returns 0x3C.
  - Required address byte: 0x43.
  - `rsp_rdata` = 0x3C.
  - Master leaves SDA released on the 9th bit of the data byte.
  - `rsp_nack` = 0.
- **No slave:** write to 0x55 with SDA only pulled up.
  - Required: STOP follows bit cell 9.
  - `rsp_nack` = 1, `rsp_rdata` = 0.
  - `rsp_valid` 41·CLK_DIV + 1 cycles after accept.
- **Reset mid-transfer:** assert `rstn` low during a WRITE data bit with `sda_oe` = 1.
  - Required: `sda_oe` = 0 and `scl_oe` = 0 in the same cycle.
  - After release: `cmd_ready` = 1 and a new write completes normally.
- **10-bit write with macro:** write addr 0x2A5, data 0x5A.
  - Required bytes: 0xF4, 0xA5, 0x5A.
  - A 10-bit read to 0x2A5 gives `rsp_nack` = 1 with SCL never pulled low.
- **10-bit address without macro:** write to addr 0x2A5.
  - Required: single address byte 0x4A.
